// File: rtl/sr_byte_feeder.sv
// sr_byte_feeder: small FIFO in front of the 74hc595 driver; issues one byte per handshake,
// enforces an idle gap between latches and flags overflow / handshake timeouts.
module sr_byte_feeder #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_W     = 3,
   parameter int unsigned GAP_CYCLES = 48,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic            i_clk,
   input  logic            i_Rst_n,
   input  logic [7:0]      i_Data,
   input  logic            i_Valid,
   input  logic            i_ClrErr,
   output logic            o_Full,
   output logic            o_Empty,
   output logic [ADDR_W:0] o_Level,
   output logic            o_Overflow,
   output logic            o_Timeout,
   output logic            o_Busy,
   output logic [7:0]      o_SR_Data,
   output logic            o_SR_Enable,
   input  logic            i_SR_Ready
);

   localparam int unsigned LvlW = ADDR_W + 1;
   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
   localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [2:0] {StIdle, StEnable, StWaitLo, StWaitHi, StGap} state_e;

   state_e            state_q;
   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [TmoW-1:0]   tmo_cnt_q;
   logic [GapW-1:0]   gap_cnt_q;
   logic [ADDR_W:0]   level_d;
   logic              wr_en;
   logic              pop;
   logic              tmo_hit;

   // Full is the registered flag, so a write while full is refused even if a pop happens now.
   assign wr_en   = i_Valid & ~o_Full;
   assign pop     = (state_q == StIdle) & ~o_Empty & i_SR_Ready;
   assign tmo_hit = (state_q == StWaitLo) & i_SR_Ready & (tmo_cnt_q == TmoW'(TIMEOUT - 1));
   assign o_Busy  = (state_q != StIdle);

   always_comb begin
      level_d = o_Level;
      if (wr_en & ~pop) begin
         level_d = o_Level + 1'b1;
      end else if (~wr_en & pop) begin
         level_d = o_Level - 1'b1;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_Data;
      end
   end

   always_ff @(posedge i_clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         o_Level    <= '0;
         o_Full     <= 1'b0;
         o_Empty    <= 1'b1;
         o_Overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         o_Level <= level_d;
         o_Full  <= (level_d == LvlW'(DEPTH));
         o_Empty <= (level_d == '0);
         if (i_Valid & o_Full) begin
            o_Overflow <= 1'b1;
         end else if (i_ClrErr) begin
            o_Overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= StIdle;
         o_SR_Data   <= '0;
         o_SR_Enable <= 1'b0;
         o_Timeout   <= 1'b0;
         tmo_cnt_q   <= '0;
         gap_cnt_q   <= '0;
      end else begin
         if (tmo_hit) begin
            o_Timeout <= 1'b1;
         end else if (i_ClrErr) begin
            o_Timeout <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  o_SR_Data   <= mem_q[rd_ptr_q];
                  o_SR_Enable <= 1'b1;
                  state_q     <= StEnable;
               end
            end
            StEnable: begin
               o_SR_Enable <= 1'b0;
               tmo_cnt_q   <= '0;
               state_q     <= StWaitLo;
            end
            StWaitLo: begin
               if (!i_SR_Ready) begin
                  state_q <= StWaitHi;
               end else if (tmo_hit) begin
                  // Driver never acknowledged: the byte is abandoned.
                  gap_cnt_q <= GapW'(GAP_CYCLES);
                  state_q   <= (GAP_CYCLES == 0) ? StIdle : StGap;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            StWaitHi: begin
               if (i_SR_Ready) begin
                  gap_cnt_q <= GapW'(GAP_CYCLES);
                  state_q   <= (GAP_CYCLES == 0) ? StIdle : StGap;
               end
            end
            StGap: begin
               gap_cnt_q <= gap_cnt_q - 1'b1;
               if (gap_cnt_q <= GapW'(1)) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_byte_feeder.sv
// Self-checking bench for sr_byte_feeder: a behavioural driver model plus a byte scoreboard
// and an abstract FIFO occupancy model.
module tb_sr_byte_feeder;

   logic       i_clk;
   logic       i_Rst_n;
   logic [7:0] i_Data;
   logic       i_Valid;
   logic       i_ClrErr;
   logic       o_Full;
   logic       o_Empty;
   logic [3:0] o_Level;
   logic       o_Overflow;
   logic       o_Timeout;
   logic       o_Busy;
   logic [7:0] o_SR_Data;
   logic       o_SR_Enable;
   logic       i_SR_Ready;

   sr_byte_feeder dut (
      .i_clk       (i_clk),
      .i_Rst_n     (i_Rst_n),
      .i_Data      (i_Data),
      .i_Valid     (i_Valid),
      .i_ClrErr    (i_ClrErr),
      .o_Full      (o_Full),
      .o_Empty     (o_Empty),
      .o_Level     (o_Level),
      .o_Overflow  (o_Overflow),
      .o_Timeout   (o_Timeout),
      .o_Busy      (o_Busy),
      .o_SR_Data   (o_SR_Data),
      .o_SR_Enable (o_SR_Enable),
      .i_SR_Ready  (i_SR_Ready)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_cmp++;
      assert (obs >= lo && obs <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Driver model: drops ready after each accepted enable, holds it low, then raises it.
   logic [7:0] exp_q [$];
   bit rdy_force_low = 1'b0;
   bit rdy_ignore    = 1'b0;
   bit rand_lo       = 1'b0;
   int lo_len        = 3;
   int busy          = 0;
   int n_recv        = 0;
   int cyc           = 0;
   int last_rise     = -1000;
   int last_gap      = 0;
   bit prev_en       = 1'b0;

   initial begin
      i_SR_Ready = 1'b1;
      forever begin
         @(negedge i_clk);
         cyc++;
         if (o_SR_Enable === 1'b1) begin
            check("en_while_ready", i_SR_Ready, 1);
            check("en_single_cycle", prev_en, 0);
            if (!rdy_ignore) begin
               last_gap = cyc - last_rise;
               n_recv++;
               check("byte_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check("byte_order", o_SR_Data, exp_q.pop_front());
               busy = rand_lo ? int'($urandom_range(1, 4)) : lo_len;
            end
         end
         prev_en = (o_SR_Enable === 1'b1);
         if (busy > 0) begin
            i_SR_Ready = 1'b0;
            busy--;
         end else begin
            if (!i_SR_Ready && !rdy_force_low) last_rise = cyc;
            i_SR_Ready = !rdy_force_low;
         end
      end
   end

   task automatic wait_recv(input int n, input int budget, input string tag);
      int k = 0;
      while (n_recv < n && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      check(tag, n_recv >= n, 1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((o_Busy !== 1'b0 || i_SR_Ready !== 1'b1 || o_Empty !== 1'b1) && k < 2000) begin
         @(negedge i_clk);
         k++;
      end
      check(tag, (o_Busy === 1'b0) && (i_SR_Ready === 1'b1), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, base, accepted, mlevel, pre;
      bit drive, acc, popped, ovf_exp;
      logic [7:0] b;

      i_Valid = 1'b0; i_Data = '0; i_ClrErr = 1'b0; i_Rst_n = 1'b1;
      #2 i_Rst_n = 1'b0;

      // Reset held with writes attempted
      @(negedge i_clk);
      i_Valid = 1'b1; i_Data = 8'h3C;
      repeat (3) @(negedge i_clk);
      check("rst_empty", o_Empty, 1);
      check("rst_level", o_Level, 0);
      check("rst_enable", o_SR_Enable, 0);
      check("rst_full", o_Full, 0);
      check("rst_ovf", o_Overflow, 0);
      check("rst_tmo", o_Timeout, 0);
      check("rst_busy", o_Busy, 0);
      i_Valid = 1'b0; i_Rst_n = 1'b1;
      @(negedge i_clk);
      check("post_rst_empty", o_Empty, 1);

      // Single byte: latency, hold, gap after ready returns
      lo_len = 40;
      exp_q.push_back(8'hA5);
      i_Valid = 1'b1; i_Data = 8'hA5;
      @(negedge i_clk);
      i_Valid = 1'b0;
      check("lat_level1", o_Level, 1);
      check("lat_no_early_en", o_SR_Enable, 0);
      @(negedge i_clk);
      check("lat_en", o_SR_Enable, 1);
      check("lat_data", o_SR_Data, 8'hA5);
      check("lat_level0", o_Level, 0);
      check("lat_busy", o_Busy, 1);
      repeat (3) @(negedge i_clk);
      exp_q.push_back(8'h5A);
      i_Valid = 1'b1; i_Data = 8'h5A;
      @(negedge i_clk);
      i_Valid = 1'b0;
      check("data_held", o_SR_Data, 8'hA5);
      wait_recv(2, 300, "single_second_sent");
      check_range("gap_after_ready", last_gap, 49, 52);

      // Burst into a stalled driver, overflow with clear in the same cycle
      lo_len = 3;
      wait_idle("idle_before_burst");
      rdy_force_low = 1'b1;
      @(negedge i_clk);
      for (int i = 1; i <= 8; i++) begin
         i_Valid = 1'b1; i_Data = 8'(i);
         exp_q.push_back(8'(i));
         @(negedge i_clk);
         check("burst_level", o_Level, i);
      end
      check("burst_full", o_Full, 1);
      check("burst_ovf_clear", o_Overflow, 0);
      i_Data = 8'hFF; i_ClrErr = 1'b1;
      @(negedge i_clk);
      i_Valid = 1'b0; i_ClrErr = 1'b0;
      check("ovf_set_wins", o_Overflow, 1);
      check("ovf_level", o_Level, 8);
      base = n_recv;
      rdy_force_low = 1'b0;
      wait_recv(base + 8, 8 * 80, "burst_drain");
      check("burst_scoreboard_empty", exp_q.size(), 0);
      i_ClrErr = 1'b1;
      @(negedge i_clk);
      i_ClrErr = 1'b0;
      check("ovf_cleared", o_Overflow, 0);

      // Random writes while draining, against an occupancy model
      wait_idle("idle_before_conc");
      rand_lo = 1'b1;
      base = n_recv; accepted = 0; mlevel = 0; k = 0; ovf_exp = 1'b0;
      while (accepted < 20 && k < 6000) begin
         drive = ($urandom_range(0, 2) == 0);
         b = 8'($urandom);
         i_Valid = drive; i_Data = b;
         pre = mlevel;
         acc = drive && (pre < 8);
         if (drive && pre == 8) ovf_exp = 1'b1;
         @(negedge i_clk);
         k++;
         popped = (o_SR_Enable === 1'b1);
         if (acc) begin
            exp_q.push_back(b);
            accepted++;
         end
         mlevel = pre + int'(acc) - int'(popped);
         check("conc_level", o_Level, mlevel);
         check("conc_full", o_Full, mlevel == 8);
      end
      i_Valid = 1'b0;
      check("conc_written", accepted, 20);
      check("conc_ovf", o_Overflow, ovf_exp);
      wait_recv(base + 20, 20 * 80, "conc_drain");
      check("conc_scoreboard_empty", exp_q.size(), 0);
      rand_lo = 1'b0;
      i_ClrErr = 1'b1;
      @(negedge i_clk);
      i_ClrErr = 1'b0;

      // Timeout: driver ignores enable
      wait_idle("idle_before_tmo");
      rdy_ignore = 1'b1;
      i_Valid = 1'b1; i_Data = 8'hC3;
      @(negedge i_clk);
      i_Valid = 1'b0;
      k = 0;
      while (o_SR_Enable !== 1'b1 && k < 10) begin
         @(negedge i_clk);
         k++;
      end
      check("tmo_en_seen", o_SR_Enable, 1);
      k = 0;
      while (o_Timeout !== 1'b1 && k < 400) begin
         @(negedge i_clk);
         k++;
      end
      check_range("tmo_cycles", k, 254, 260);
      check("tmo_busy_gap", o_Busy, 1);
      rdy_ignore = 1'b0;
      base = n_recv;
      exp_q.push_back(8'h3C);
      i_Valid = 1'b1; i_Data = 8'h3C;
      @(negedge i_clk);
      i_Valid = 1'b0;
      wait_recv(base + 1, 200, "tmo_next_byte");
      check("tmo_sticky", o_Timeout, 1);
      i_ClrErr = 1'b1;
      @(negedge i_clk);
      i_ClrErr = 1'b0;
      check("tmo_cleared", o_Timeout, 0);

      // Reset during WAIT_HI with ready low
      wait_idle("idle_before_rst");
      lo_len = 30;
      exp_q.push_back(8'h11);
      i_Valid = 1'b1; i_Data = 8'h11;
      @(negedge i_clk);
      i_Data = 8'h22;
      @(negedge i_clk);
      i_Data = 8'h33;
      @(negedge i_clk);
      i_Valid = 1'b0;
      check("mid_level", o_Level, 2);
      repeat (4) @(negedge i_clk);
      check("mid_busy", o_Busy, 1);
      check("mid_ready_low", i_SR_Ready, 0);
      i_Rst_n = 1'b0;
      #1;
      check("mid_rst_en", o_SR_Enable, 0);
      check("mid_rst_busy", o_Busy, 0);
      check("mid_rst_empty", o_Empty, 1);
      check("mid_rst_level", o_Level, 0);
      @(negedge i_clk);
      i_Rst_n = 1'b1;
      base = n_recv;
      check("rel_ready_low", i_SR_Ready, 0);
      exp_q.push_back(8'h44);
      i_Valid = 1'b1; i_Data = 8'h44;
      @(negedge i_clk);
      i_Valid = 1'b0;
      k = 0;
      while (i_SR_Ready !== 1'b1 && k < 60) begin
         check("no_en_ready_low", o_SR_Enable, 0);
         @(negedge i_clk);
         k++;
      end
      wait_recv(base + 1, 20, "rel_byte_sent");
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
